// File: rtl/l1_cache_2way.sv
// Two-way set-associative write-back L1 cache.
// 32-bit CPU word port in front, whole-line pmem port behind.
module l1_cache_2way #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   mem_address,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [3:0]                    mem_byte_enable,
  input  logic [31:0]                   mem_wdata,
  output logic [31:0]                   mem_rdata,
  output logic                          mem_resp,
  output logic [31:0]                   pmem_address,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
  input  logic                          pmem_resp
);

  localparam int NSETS = 2**S_INDEX;
  localparam int LINEW = 8*(2**S_OFFSET);
  localparam int WBITS = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t             r_state;
  logic               r_victim;
  logic [LINEW-1:0]   r_data  [2][NSETS];
  logic [S_TAG-1:0]   r_tag   [2][NSETS];
  logic [NSETS-1:0]   r_valid [2];
  logic [NSETS-1:0]   r_dirty [2];
  logic [NSETS-1:0]   r_lru;

  logic [S_INDEX-1:0] w_set;
  logic [S_TAG-1:0]   w_tag;
  logic [WBITS-1:0]   w_word;
  logic [1:0]         w_hit;
  logic               w_hit_any;
  logic               w_hway;
  logic               w_req;
  logic               w_idle;
  logic               w_vnew;
  logic [LINEW-1:0]   w_line;
  logic               w_unused;

  assign w_set  = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_tag  = mem_address[31:S_OFFSET+S_INDEX];
  assign w_word = mem_address[S_OFFSET-1:2];
  assign w_unused = ^mem_address[1:0];

  assign w_hit[0] = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
  assign w_hit[1] = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
  assign w_hit_any = |w_hit;
  assign w_hway    = ~w_hit[0];
  assign w_req     = mem_read | mem_write;
  assign w_idle    = (r_state == IDLE);

  // Invalid ways are filled first; otherwise the LRU way is evicted.
  assign w_vnew = !r_valid[0][w_set] ? 1'b0 :
                  !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];

  assign w_line    = r_data[w_hway][w_set];
  assign mem_resp  = w_idle && w_req && w_hit_any;
  assign mem_rdata = mem_resp ? w_line[{w_word, 5'b0} +: 32] : 32'h0;

  assign pmem_read  = (r_state == FILL);
  assign pmem_write = (r_state == WRITEBACK);
  assign pmem_wdata = r_data[r_victim][w_set];

  always_comb begin
    pmem_address = 32'h0;
    unique case (1'b1)
      pmem_write:
        pmem_address = {r_tag[r_victim][w_set], w_set,
                        {S_OFFSET{1'b0}}};
      pmem_read:
        pmem_address = {mem_address[31:S_OFFSET],
                        {S_OFFSET{1'b0}}};
      default: pmem_address = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_victim   <= 1'b0;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req && w_hit_any) begin
            r_lru[w_set] <= ~w_hway;
            if (mem_write) r_dirty[w_hway][w_set] <= 1'b1;
          end else if (w_req) begin
            r_victim <= w_vnew;
            if (r_valid[w_vnew][w_set] && r_dirty[w_vnew][w_set])
              r_state <= WRITEBACK;
            else
              r_state <= FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            r_dirty[r_victim][w_set] <= 1'b0;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            r_valid[r_victim][w_set] <= 1'b1;
            r_dirty[r_victim][w_set] <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data and tags carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_resp && mem_write) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_byte_enable[i])
            r_data[w_hway][w_set][{w_word, i[1:0], 3'b000} +: 8]
              <= mem_wdata[8*i +: 8];
        end
      end
      if (pmem_read && pmem_resp) begin
        r_data[r_victim][w_set] <= pmem_rdata;
        r_tag[r_victim][w_set]  <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_2way.sv
// Directed bench for l1_cache_2way.
// Line memory answers four cycles after a request is first seen.
module tb_l1_cache_2way;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  l1_cache_2way dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] pm [64];
  int           n_rd;
  int           n_wb;
  logic [31:0]  last_rd_addr;
  logic [31:0]  last_wb_addr;
  int           n_chk;
  int           n_fail;

  task automatic chk(input string tag, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    int cnt;
    cnt = 0;
    n_rd = 0;
    n_wb = 0;
    last_rd_addr = '0;
    last_wb_addr = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 8; j++)
        pm[i][32*j +: 32] = 32'h1000_0000 + 32'(i*256 + j);
    pm[8][63:32] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 4) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pm[pmem_address[10:5]] = pmem_wdata;
            n_wb++;
            last_wb_addr = pmem_address;
          end else begin
            pmem_rdata = pm[pmem_address[10:5]];
            n_rd++;
            last_rd_addr = pmem_address;
          end
        end
      end
    end
  end

  task automatic cpu(input logic [31:0] a, input logic r, input logic w,
                     input logic [3:0] be, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    bit got;
    got = 1'b0;
    rd = '0;
    lat = -1;
    @(negedge clk);
    mem_address = a;
    mem_read = r;
    mem_write = w;
    mem_byte_enable = be;
    mem_wdata = wd;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      chk("pmem_excl", {255'b0, pmem_read & pmem_write}, 256'b0);
      if (mem_resp) begin
        got = 1'b1;
        rd = mem_rdata;
        lat = i;
      end
      @(negedge clk);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (!got) chk("resp_timeout", 256'd0, 256'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input int exp_lat);
    logic [31:0] d;
    int lat;
    cpu(a, 1'b1, 1'b0, 4'h0, 32'h0, d, lat);
    chk({tag, "_data"}, 256'(d), 256'(exp_d));
    chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int exp_lat);
    logic [31:0] d;
    int lat;
    cpu(a, 1'b0, 1'b1, be, wd, d, lat);
    chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    int rd_before;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = '0;
    mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 256'(mem_resp), 256'd0);
    chk("rst_pread", 256'(pmem_read), 256'd0);
    chk("rst_pwrite", 256'(pmem_write), 256'd0);
    chk("rst_paddr", 256'(pmem_address), 256'd0);
    chk("rst_rdata", 256'(mem_rdata), 256'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss then hit
    rd_chk("cold", 32'h104, 32'hDEAD_BEEF, 5);
    chk("cold_nrd", 256'(n_rd), 256'd1);
    chk("cold_raddr", 256'(last_rd_addr), 256'h100);
    rd_chk("rehit", 32'h104, 32'hDEAD_BEEF, 0);
    chk("rehit_nrd", 256'(n_rd), 256'd1);

    // Byte merge on a write hit
    wr_chk("wfull", 32'h104, 4'hF, 32'h1122_3344, 0);
    wr_chk("wpart", 32'h104, 4'b0101, 32'hAABB_CCDD, 0);
    rd_chk("merge", 32'h104, 32'h11BB_33DD, 0);
    chk("merge_nwb", 256'(n_wb), 256'd0);

    // Dirty eviction of way 0
    rd_chk("fill200", 32'h200, 32'h1000_1000, 5);
    rd_chk("touch200", 32'h200, 32'h1000_1000, 0);
    rd_chk("evict", 32'h300, 32'h1000_1800, 9);
    chk("evict_nwb", 256'(n_wb), 256'd1);
    chk("evict_waddr", 256'(last_wb_addr), 256'h100);
    chk("evict_w1", 256'(pm[8][63:32]), 256'h11BB_33DD);
    chk("evict_w0", 256'(pm[8][31:0]), 256'h1000_0800);
    chk("evict_raddr", 256'(last_rd_addr), 256'h300);
    rd_chk("keep200", 32'h200, 32'h1000_1000, 0);
    rd_chk("back100", 32'h104, 32'h11BB_33DD, 5);
    rd_chk("still200", 32'h200, 32'h1000_1000, 0);

    // Clean LRU replacement
    rd_chk("lru_t100", 32'h100, 32'h1000_0800, 0);
    rd_chk("lru_300", 32'h300, 32'h1000_1800, 5);
    chk("lru_nwb", 256'(n_wb), 256'd1);
    rd_chk("lru_h100", 32'h100, 32'h1000_0800, 0);
    rd_chk("lru_m200", 32'h200, 32'h1000_1000, 5);

    // Read+write together acts as a write
    cpu(32'h100, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, d, lat);
    chk("rw_lat", 256'(lat), 256'd0);
    #1;
    chk("rw_pulse", 256'(mem_resp), 256'd0);
    rd_chk("rw_read", 32'h100, 32'hCAFE_F00D, 0);

    // Reset during a fill
    rd_before = n_rd;
    @(negedge clk);
    mem_address = 32'h480;
    mem_read = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_pread", 256'(pmem_read), 256'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_pread", 256'(pmem_read), 256'd0);
    chk("mid_rst_resp", 256'(mem_resp), 256'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_nrd", 256'(n_rd), 256'(rd_before));
    rd_chk("post_480", 32'h480, 32'h1000_2400, 5);
    rd_chk("post_100", 32'h100, 32'h1000_0800, 5);
    rd_chk("post_104", 32'h104, 32'h11BB_33DD, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
